// File: rtl/bp_stream_mem_arbiter.sv
// bp_stream_mem_arbiter: round-robin N:1 BP stream arbiter that keeps locked multi-beat messages atomic.
// Define BP_STREAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module bp_stream_mem_arbiter #(
  parameter int num_req_p = 2,
  parameter int header_width_p = 64,
  parameter int data_width_p = 64,
  localparam int lg_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [num_req_p*header_width_p-1:0] mem_header_i,
  input  logic [num_req_p*data_width_p-1:0]   mem_data_i,
  input  logic [num_req_p-1:0]                mem_v_i,
  input  logic [num_req_p-1:0]                mem_lock_i,
  output logic [num_req_p-1:0]                mem_ready_o,
  output logic [header_width_p-1:0]           mem_header_o,
  output logic [data_width_p-1:0]             mem_data_o,
  output logic                                mem_v_o,
  output logic                                mem_lock_o,
  input  logic                                mem_ready_i,
  output logic [lg_req_lp-1:0]                grant_id_o
);
  typedef enum logic {IDLE, BUSY} state_e;
  state_e state_q, state_d;
  logic [lg_req_lp-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, start, pick;
  logic [num_req_p-1:0] cand;
  logic busy, fin;
  assign busy = state_q == BUSY;
  assign fin = mem_v_o & mem_ready_i & ~mem_lock_o;
  assign grant_id_o = grant_q;
  always_comb begin
    mem_header_o = '0;
    mem_data_o = '0;
    mem_v_o = 1'b0;
    mem_lock_o = 1'b0;
    mem_ready_o = '0;
    for (int i = 0; i < num_req_p; i++)
      if (grant_q == lg_req_lp'(i)) begin
        mem_header_o = mem_header_i[i*header_width_p +: header_width_p];
        mem_data_o = mem_data_i[i*data_width_p +: data_width_p];
        mem_v_o = busy & mem_v_i[i];
        mem_lock_o = busy & mem_lock_i[i];
        mem_ready_o[i] = busy & mem_ready_i;
      end
  end
`ifdef BP_STREAM_ARB_FIXED_PRIO_EN
  assign start = rr_ptr_q;
  assign cand = mem_v_i;
`else
  logic [lg_req_lp-1:0] nxt_g;
  assign nxt_g = (int'(grant_q) == num_req_p - 1) ? '0 : grant_q + lg_req_lp'(1);
  // while busy the current owner is excluded so it cannot win twice in a row
  assign start = busy ? nxt_g : rr_ptr_q;
  assign cand = busy ? mem_v_i & ~(num_req_p'(1) << grant_q) : mem_v_i;
`endif
  always_comb begin
    int d, best;
    d = 0;
    best = num_req_p;
    pick = '0;
    for (int i = 0; i < num_req_p; i++) begin
      d = i - int'(start);
      if (d < 0) d = d + num_req_p;
      if (cand[i] && d < best) begin
        best = d;
        pick = lg_req_lp'(i);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (!busy || fin) begin
      state_d = (|cand) ? BUSY : IDLE;
      grant_d = (|cand) ? pick : grant_q;
    end
`ifndef BP_STREAM_ARB_FIXED_PRIO_EN
    if (busy && fin) rr_ptr_d = nxt_g;
`endif
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
endmodule

// File: tb/tb_bp_stream_mem_arbiter.sv
// tb_bp_stream_mem_arbiter: vector table plus scoreboarded sequences for a 3-master arbiter.
module tb_bp_stream_mem_arbiter;
  logic clk, rst_n, v_o, lk_o, rdy_i, sb_on;
  logic [2:0] v, lk, rdy_o;
  logic [1:0] gid;
  logic [47:0] hdr_flat, dat_flat;
  logic [15:0] hdr_o, dat_o;
  logic [15:0] dat [3];
  int checks = 0, failures = 0;
  typedef struct {
    logic [2:0] v, lk;
    logic rdy, ev;
    logic [1:0] eg;
    logic [2:0] er;
    logic el;
  } vec_t;
  typedef struct packed {
    logic [1:0] g;
    logic [15:0] h, d;
  } exp_t;
  vec_t tbl [18];
  exp_t q [$];
  exp_t mon_e;
  bp_stream_mem_arbiter #(.num_req_p(3), .header_width_p(16), .data_width_p(16)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .mem_header_i(hdr_flat), .mem_data_i(dat_flat),
    .mem_v_i(v), .mem_lock_i(lk), .mem_ready_o(rdy_o), .mem_header_o(hdr_o),
    .mem_data_o(dat_o), .mem_v_o(v_o), .mem_lock_o(lk_o), .mem_ready_i(rdy_i),
    .grant_id_o(gid)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always_comb begin
    hdr_flat = '0;
    dat_flat = '0;
    for (int i = 0; i < 3; i++) begin
      hdr_flat[i*16 +: 16] = 16'hA000 + 16'(i);
      dat_flat[i*16 +: 16] = dat[i];
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic push(input logic [1:0] g);
    q.push_back('{g: g, h: 16'hA000 + 16'(g), d: dat[g]});
  endtask
  always @(negedge clk)
    if (sb_on && v_o && rdy_i) begin
      if (q.size() == 0) chk("sb_unexpected_beat", 1, 0);
      else begin
        mon_e = q.pop_front();
        chk("sb_grant", 32'(gid), 32'(mon_e.g));
        chk("sb_header", 32'(hdr_o), 32'(mon_e.h));
        chk("sb_data", 32'(dat_o), 32'(mon_e.d));
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0]  = '{3'b010, 3'b000, 1, 0, 0, 3'b000, 0};
    tbl[1]  = '{3'b010, 3'b000, 1, 1, 1, 3'b010, 0};
    tbl[2]  = '{3'b000, 3'b000, 1, 0, 1, 3'b000, 0};
    tbl[3]  = '{3'b011, 3'b001, 1, 0, 1, 3'b000, 0};
    tbl[4]  = '{3'b011, 3'b001, 1, 1, 0, 3'b001, 1};
    tbl[5]  = '{3'b011, 3'b001, 1, 1, 0, 3'b001, 1};
    tbl[6]  = '{3'b011, 3'b001, 1, 1, 0, 3'b001, 1};
    tbl[7]  = '{3'b011, 3'b000, 1, 1, 0, 3'b001, 0};
    tbl[8]  = '{3'b010, 3'b000, 1, 1, 1, 3'b010, 0};
    tbl[9]  = '{3'b000, 3'b000, 1, 0, 1, 3'b000, 0};
    tbl[10] = '{3'b001, 3'b001, 1, 0, 1, 3'b000, 0};
    tbl[11] = '{3'b001, 3'b001, 1, 1, 0, 3'b001, 1};
    tbl[12] = '{3'b110, 3'b000, 1, 0, 0, 3'b001, 0};
    tbl[13] = '{3'b111, 3'b000, 0, 1, 0, 3'b000, 0};
    tbl[14] = '{3'b111, 3'b000, 1, 1, 0, 3'b001, 0};
    tbl[15] = '{3'b000, 3'b000, 1, 0, 1, 3'b010, 0};
    tbl[16] = '{3'b010, 3'b000, 1, 1, 1, 3'b010, 0};
    tbl[17] = '{3'b000, 3'b000, 1, 0, 1, 3'b000, 0};
    sb_on = 0;
    rdy_i = 1;
    v = 3'b111;
    lk = 3'b000;
    for (int i = 0; i < 3; i++) dat[i] = 16'hD000 + 16'(i);
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_v_o", 32'(v_o), 0);
    chk("reset_ready_o", 32'(rdy_o), 0);
    chk("reset_grant", 32'(gid), 0);
    chk("reset_lock_o", 32'(lk_o), 0);
    rst_n = 1;
    v = 3'b000;
    @(posedge clk); #1;
    for (int r = 0; r < 18; r++) begin
      v = tbl[r].v;
      lk = tbl[r].lk;
      rdy_i = tbl[r].rdy;
      @(negedge clk);
      chk($sformatf("row%0d_v_o", r), 32'(v_o), 32'(tbl[r].ev));
      chk($sformatf("row%0d_grant", r), 32'(gid), 32'(tbl[r].eg));
      chk($sformatf("row%0d_ready_o", r), 32'(rdy_o), 32'(tbl[r].er));
      chk($sformatf("row%0d_lock_o", r), 32'(lk_o), 32'(tbl[r].el));
      @(posedge clk); #1;
    end
    // backpressure on m2's second beat of a 3-beat message
    sb_on = 1;
    v = 3'b100;
    lk = 3'b100;
    rdy_i = 1;
    dat[2] = 16'hD200;
    push(2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    dat[2] = 16'hD201;
    rdy_i = 0;
    push(2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_v_o", 32'(v_o), 1);
      chk("stall_grant", 32'(gid), 2);
      chk("stall_header", 32'(hdr_o), 32'hA002);
      chk("stall_data", 32'(dat_o), 32'hD201);
      chk("stall_lock_o", 32'(lk_o), 1);
      chk("stall_ready_o", 32'(rdy_o), 0);
      @(posedge clk); #1;
    end
    rdy_i = 1;
    @(posedge clk); #1;
    dat[2] = 16'hD202;
    lk = 3'b000;
    push(2);
    @(posedge clk); #1;
    v = 3'b000;
    @(negedge clk);
    chk("after_fin_idle_v_o", 32'(v_o), 0);
    @(posedge clk); #1;
    // async reset in the middle of m2's locked message
    v = 3'b010;
    dat[1] = 16'hD110;
    push(1);
    @(posedge clk); #1;
    v = 3'b110;
    lk = 3'b100;
    dat[2] = 16'hD210;
    @(posedge clk); #1;
    chk("pre_reset_grant", 32'(gid), 2);
    chk("pre_reset_v_o", 32'(v_o), 1);
    #1 rst_n = 0;
    #1;
    chk("async_v_o", 32'(v_o), 0);
    chk("async_ready_o", 32'(rdy_o), 0);
    chk("async_grant", 32'(gid), 0);
    chk("async_lock_o", 32'(lk_o), 0);
    v = 3'b111;
    lk = 3'b000;
    for (int i = 0; i < 3; i++) dat[i] = 16'hD300 + 16'(i);
    #2 rst_n = 1;
    for (int i = 0; i < 6; i++) push(2'(i % 3));
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_no_bubble", 32'(v_o), 1);
      @(posedge clk);
    end
    #1 v = 3'b000;
    @(negedge clk);
    chk("sb_drained", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
